// File: rtl/prefix_pkg.sv
// Shared definitions for the pipelined prefix adder/subtractor:
// depth/latency helpers and flag bit positions for packed flag vectors.
package prefix_pkg;

    // Bit positions used when carry/overflow/zero are packed into 3 bits.
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;

    // Smallest r with 2**r >= n (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of Kogge-Stone combine levels for a given operand width.
    function automatic int levels(input int width);
        return clog2(width);
    endfunction

    // Number of register banks placed between groups of prefix levels.
    function automatic int banks(input int width, input int split);
        return (levels(width) + split - 1) / split;
    endfunction

    // Cycles from input acceptance to result presentation.
    function automatic int lat(input int width, input int split);
        return 1 + banks(width, split);
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone combine level: merges each (g,p) pair with the pair
// DIST bits below it. Bits below DIST have no partner and pass through.
module prefix_level
    import prefix_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    // Group generate/propagate combine at distance DIST.
    always_comb begin
        g_out = g_in;
        p_out = p_in;
        for (int i = DIST; i < WIDTH; i++) begin
            g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
            p_out[i] = p_in[i] & p_in[i-DIST];
        end
    end

endmodule

// File: rtl/pipelined_prefix_alu.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Stage 0 registers the operands (with y inverted and carry forced for
// subtraction), a register bank follows every SPLIT prefix levels, and a
// final stage forms the sum, flags and output register.
// Optional build macro: PIPELINED_PREFIX_ALU_SATURATE_EN clamps z to the
// signed limit on overflow (carry_out/overflow still report the raw sum).
//
// Handshake: a beat moves on any edge where the pipeline advances;
// advance = ~out_valid | out_ready is a single global stall, in_ready is
// advance itself, an input beat is taken when in_valid & in_ready, and
// the output beat is consumed when out_valid & out_ready. While stalled,
// every stage (including z and the flags) holds.
module pipelined_prefix_alu
    import prefix_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SPLIT = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int LEVELS = levels(WIDTH);
    localparam int NBANK  = banks(WIDTH, SPLIT);

    if (WIDTH < 2) begin : g_bad_width
        $error("pipelined_prefix_alu: WIDTH must be at least 2");
    end
    if (SPLIT < 1) begin : g_bad_split
        $error("pipelined_prefix_alu: SPLIT must be at least 1");
    end

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage 0 state: operands already conditioned for add or subtract.
    logic             s0_valid;
    logic [WIDTH-1:0] s0_x;
    logic [WIDTH-1:0] s0_y;
    logic             s0_cin;
    logic [WIDTH-1:0] s0_g;
    logic [WIDTH-1:0] s0_p;

    // Capture the incoming beat (or a bubble) whenever the pipe advances.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s0_valid <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
            s0_cin   <= 1'b0;
        end else if (advance) begin
            s0_valid <= in_valid;
            s0_x     <= x;
            s0_y     <= sub ? ~y : y;
            s0_cin   <= sub | carry_in;
        end
    end

    assign s0_g = s0_x & s0_y;
    assign s0_p = s0_x ^ s0_y;

    // Prefix level wiring: lvl_*i feed level k, lvl_*o come out of it.
    logic [WIDTH-1:0] lvl_gi [LEVELS];
    logic [WIDTH-1:0] lvl_pi [LEVELS];
    logic [WIDTH-1:0] lvl_go [LEVELS];
    logic [WIDTH-1:0] lvl_po [LEVELS];

    // Register banks between level groups; d_* are their inputs.
    logic             bank_valid [1:NBANK];
    logic [WIDTH-1:0] bank_g     [1:NBANK];
    logic [WIDTH-1:0] bank_p     [1:NBANK];
    logic [WIDTH-1:0] bank_hs    [1:NBANK];
    logic             bank_cin   [1:NBANK];
    logic             bank_xm    [1:NBANK];
    logic             bank_ym    [1:NBANK];

    logic             d_valid [1:NBANK];
    logic [WIDTH-1:0] d_g     [1:NBANK];
    logic [WIDTH-1:0] d_p     [1:NBANK];
    logic [WIDTH-1:0] d_hs    [1:NBANK];
    logic             d_cin   [1:NBANK];
    logic             d_xm    [1:NBANK];
    logic             d_ym    [1:NBANK];

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        if (k == 0) begin : g_from_s0
            assign lvl_gi[k] = s0_g;
            assign lvl_pi[k] = s0_p;
        end else if ((k % SPLIT) == 0) begin : g_from_bank
            assign lvl_gi[k] = bank_g[k / SPLIT];
            assign lvl_pi[k] = bank_p[k / SPLIT];
        end else begin : g_from_prev
            assign lvl_gi[k] = lvl_go[k-1];
            assign lvl_pi[k] = lvl_po[k-1];
        end

        prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .g_in  (lvl_gi[k]),
            .p_in  (lvl_pi[k]),
            .g_out (lvl_go[k]),
            .p_out (lvl_po[k])
        );
    end

    for (genvar b = 1; b <= NBANK; b++) begin : g_bank_in
        // Last level feeding this bank: end of its SPLIT-sized group.
        localparam int LAST = (((b * SPLIT) < LEVELS) ? (b * SPLIT) : LEVELS) - 1;

        assign d_g[b] = lvl_go[LAST];
        assign d_p[b] = lvl_po[LAST];

        if (b == 1) begin : g_side_s0
            assign d_valid[b] = s0_valid;
            assign d_hs[b]    = s0_p;
            assign d_cin[b]   = s0_cin;
            assign d_xm[b]    = s0_x[WIDTH-1];
            assign d_ym[b]    = s0_y[WIDTH-1];
        end else begin : g_side_bank
            assign d_valid[b] = bank_valid[b-1];
            assign d_hs[b]    = bank_hs[b-1];
            assign d_cin[b]   = bank_cin[b-1];
            assign d_xm[b]    = bank_xm[b-1];
            assign d_ym[b]    = bank_ym[b-1];
        end
    end

    // Shift every intermediate bank forward together on advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 1; b <= NBANK; b++) begin
                bank_valid[b] <= 1'b0;
                bank_g[b]     <= '0;
                bank_p[b]     <= '0;
                bank_hs[b]    <= '0;
                bank_cin[b]   <= 1'b0;
                bank_xm[b]    <= 1'b0;
                bank_ym[b]    <= 1'b0;
            end
        end else if (advance) begin
            for (int b = 1; b <= NBANK; b++) begin
                bank_valid[b] <= d_valid[b];
                bank_g[b]     <= d_g[b];
                bank_p[b]     <= d_p[b];
                bank_hs[b]    <= d_hs[b];
                bank_cin[b]   <= d_cin[b];
                bank_xm[b]    <= d_xm[b];
                bank_ym[b]    <= d_ym[b];
            end
        end
    end

    // Final stage: carries from group (G,P) plus carry-in, then sum/flags.
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic             sum_ovf;
    logic [WIDTH-1:0] result;

    // Carry into bit i is G[i-1:0] | (P[i-1:0] & cin).
    always_comb begin
        carry    = '0;
        carry[0] = bank_cin[NBANK];
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = bank_g[NBANK][i-1] | (bank_p[NBANK][i-1] & bank_cin[NBANK]);
        end
        sum      = bank_hs[NBANK] ^ carry;
        sum_cout = bank_g[NBANK][WIDTH-1] | (bank_p[NBANK][WIDTH-1] & bank_cin[NBANK]);
        sum_ovf  = (bank_xm[NBANK] == bank_ym[NBANK]) && (sum[WIDTH-1] != bank_xm[NBANK]);
    end

`ifdef PIPELINED_PREFIX_ALU_SATURATE_EN
    // Clamp to the signed limit in the direction of the overflow.
    always_comb begin
        result = sum;
        if (sum_ovf) begin
            result = bank_xm[NBANK] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign result = sum;
`endif

    // Output register; data only loads for real beats so bubbles leave z alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            z         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= bank_valid[NBANK];
            if (bank_valid[NBANK]) begin
                z         <= result;
                carry_out <= sum_cout;
                overflow  <= sum_ovf;
                zero      <= (result == '0);
            end
        end
    end

endmodule
